// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator command executor.
// Provides the data width, key-code map, FSM state encoding and a
// magnitude helper used by the divider.
package rpn_pkg;

  localparam int DATA_W = 32;
  localparam int KEY_W  = 5;
  localparam int CNT_W  = 6;

  // Codes 0..9 are digits; anything above KEY_CLEAR is a no-op.
  localparam logic [KEY_W-1:0] KEY_ENTER = 5'd10;
  localparam logic [KEY_W-1:0] KEY_ADD   = 5'd11;
  localparam logic [KEY_W-1:0] KEY_SUB   = 5'd12;
  localparam logic [KEY_W-1:0] KEY_MUL   = 5'd13;
  localparam logic [KEY_W-1:0] KEY_DIV   = 5'd14;
  localparam logic [KEY_W-1:0] KEY_NEG   = 5'd15;
  localparam logic [KEY_W-1:0] KEY_DROP  = 5'd16;
  localparam logic [KEY_W-1:0] KEY_CLEAR = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SETTLE = 2'd2,
    DIV    = 2'd3
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (DATA_W'(0) - v) : v;
  endfunction

endpackage

// File: rtl/rpn_divider.sv
// Iterative restoring signed divider, quotient truncated toward zero.
// Ports: start latches dividend/divisor; done is high for the one sign-fix
// cycle, during which quotient holds the signed result.
module rpn_divider
  import rpn_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int CW    = $clog2(DIV_CYCLES + 1);
  // With fewer iterations than DATA_W only the low DIV_CYCLES bits of the
  // dividend magnitude are consumed, so they are pre-aligned to the top.
  localparam int SHIFT = DATA_W - DIV_CYCLES;

  logic              active;
  logic              fix;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvsr;
  logic              neg;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  assign shifted = {rem, quo[DATA_W-1]};
  // Top bit of diff set means the trial subtraction borrowed: restore.
  assign diff    = shifted - {1'b0, dvsr};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      fix    <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      fix    <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= abs_val(dividend) << SHIFT;
      dvsr   <= abs_val(divisor);
      neg    <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
    end else if (active) begin
      if (fix) begin
        active <= 1'b0;
        fix    <= 1'b0;
      end else begin
        if (!diff[DATA_W]) begin
          rem <= diff[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], 1'b1};
        end else begin
          rem <= shifted[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DIV_CYCLES - 1)) begin
          fix <= 1'b1;
        end
      end
    end
  end

  assign done     = active && fix;
  assign quotient = neg ? (DATA_W'(0) - quo) : quo;

endmodule

// File: rtl/rpn_executor.sv
// RPN command executor: turns accepted key codes into single-cycle stack
// control pulses (push / pop / write / clear) and sticky error flags.
// Ports: key_valid/key_code/key_ready keypad handshake; stack_top/next/count
// read back from the operand stack; stack_* controls; busy while dividing.
module rpn_executor
  import rpn_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  output logic              key_ready,
  input  logic [DATA_W-1:0] stack_top,
  input  logic [DATA_W-1:0] stack_next,
  input  logic [CNT_W-1:0]  stack_count,
  output logic              stack_push,
  output logic              stack_pop,
  output logic              stack_write,
  output logic              stack_clear,
  output logic [DATA_W-1:0] stack_value,
  output logic              busy,
  output logic              err_underflow,
  output logic              err_divzero,
  output logic              err_full
);

  state_t            state;
  state_t            state_next;

  logic [KEY_W-1:0]  op_key;
  logic [DATA_W-1:0] op_top;
  logic [DATA_W-1:0] op_next;
  logic [CNT_W-1:0]  op_count;
  logic [DATA_W-1:0] div_res;
  logic [DATA_W-1:0] bin_res;

  logic              accept;
  logic              div_go;
  logic              div_done;
  logic [DATA_W-1:0] div_q;
  logic              one_elem;
  logic              is_binary;

  assign accept    = key_valid && (state == IDLE);
  // Only a divide that will actually produce a result enters the DIV state;
  // underflow and divide-by-zero take the short EXEC/SETTLE path.
  assign div_go    = accept && (key_code == KEY_DIV) &&
                     (stack_count != CNT_W'(1)) && (stack_top != '0);
  assign one_elem  = (op_count == CNT_W'(1));
  assign is_binary = (op_key >= KEY_ADD) && (op_key <= KEY_DIV);

  rpn_divider #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_go),
    .dividend (stack_next),
    .divisor  (stack_top),
    .done     (div_done),
    .quotient (div_q)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = div_go ? DIV : EXEC;
      EXEC:    state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      DIV:     if (div_done) state_next = EXEC;
      default: state_next = IDLE;
    endcase
  end

  // Operands are frozen at acceptance so the stack may change underneath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_key   <= '0;
      op_top   <= '0;
      op_next  <= '0;
      op_count <= '0;
    end else if (accept) begin
      op_key   <= key_code;
      op_top   <= stack_top;
      op_next  <= stack_next;
      op_count <= stack_count;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_res <= '0;
    end else if (div_done) begin
      div_res <= div_q;
    end
  end

  // Sticky error flags, updated at the end of the EXEC cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_underflow <= 1'b0;
      err_divzero   <= 1'b0;
      err_full      <= 1'b0;
    end else if (state == EXEC) begin
      if (op_key == KEY_CLEAR) begin
        err_underflow <= 1'b0;
        err_divzero   <= 1'b0;
        err_full      <= 1'b0;
      end else if (op_key == KEY_ENTER) begin
        if (op_count == '0) err_full <= 1'b1;
      end else if (is_binary) begin
        if (one_elem) begin
          err_underflow <= 1'b1;
        end else if (op_key == KEY_DIV && op_top == '0) begin
          err_divzero <= 1'b1;
        end
      end
    end
  end

  // Binary operator result, low DATA_W bits only.
  always_comb begin
    bin_res = div_res;
    case (op_key)
      KEY_ADD: bin_res = op_next + op_top;
      KEY_SUB: bin_res = op_next - op_top;
      KEY_MUL: bin_res = op_next * op_top;
      default: bin_res = div_res;
    endcase
  end

  // Outputs
  always_comb begin
    key_ready   = (state == IDLE);
    busy        = (state == DIV);
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    stack_write = 1'b0;
    stack_clear = 1'b0;
    stack_value = '0;
    if (state == EXEC) begin
      if (op_key < KEY_ENTER) begin
        stack_write = 1'b1;
        stack_value = op_top * DATA_W'(10) + DATA_W'(op_key);
      end else begin
        case (op_key)
          KEY_ENTER: stack_push = (op_count != '0);
          KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: begin
            if (!one_elem && !(op_key == KEY_DIV && op_top == '0)) begin
              stack_pop   = 1'b1;
              stack_write = 1'b1;
              stack_value = bin_res;
            end
          end
          KEY_NEG: begin
            stack_write = 1'b1;
            stack_value = DATA_W'(0) - op_top;
          end
          KEY_DROP: begin
            // The last element is never removed, only zeroed.
            if (one_elem) begin
              stack_write = 1'b1;
            end else begin
              stack_pop = 1'b1;
            end
          end
          KEY_CLEAR: stack_clear = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rpn_executor.sv
// Directed test for rpn_executor against a behavioural 64-entry stack.
module tb_rpn_executor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic        key_ready;
  logic [31:0] stack_top;
  logic [31:0] stack_next;
  logic [5:0]  stack_count;
  logic        stack_push, stack_pop, stack_write, stack_clear;
  logic [31:0] stack_value;
  logic        busy, err_underflow, err_divzero, err_full;

  int total = 0;
  int bad   = 0;

  // Behavioural operand stack; sp = number of elements (1..64).
  logic [31:0] mem [64];
  logic [6:0]  sp;
  logic        model_rst = 1'b1;
  int          n_write = 0;
  int          n_pop = 0;
  int          n_both = 0;

  always #10 clock = ~clock;

  rpn_executor #(.DIV_CYCLES(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ready     (key_ready),
    .stack_top     (stack_top),
    .stack_next    (stack_next),
    .stack_count   (stack_count),
    .stack_push    (stack_push),
    .stack_pop     (stack_pop),
    .stack_write   (stack_write),
    .stack_clear   (stack_clear),
    .stack_value   (stack_value),
    .busy          (busy),
    .err_underflow (err_underflow),
    .err_divzero   (err_divzero),
    .err_full      (err_full)
  );

  always_comb begin
    stack_top   = mem[sp[5:0] - 6'd1];
    stack_next  = (sp >= 7'd2) ? mem[sp[5:0] - 6'd2] : 32'd0;
    stack_count = sp[5:0];
  end

  always @(posedge clock) begin
    if (model_rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      sp <= 7'd1;
    end else begin
      if (stack_write) n_write <= n_write + 1;
      if (stack_pop) n_pop <= n_pop + 1;
      if (stack_push && stack_pop) n_both <= n_both + 1;
      if (stack_clear) begin
        sp <= 7'd1;
        mem[0] <= '0;
      end else if (stack_push) begin
        if (sp < 7'd64) begin
          mem[sp[5:0]] <= '0;
          sp <= sp + 7'd1;
        end
      end else if (stack_pop && stack_write) begin
        mem[sp[5:0] - 6'd2] <= stack_value;
        sp <= sp - 7'd1;
      end else if (stack_pop) begin
        sp <= sp - 7'd1;
      end else if (stack_write) begin
        mem[sp[5:0] - 6'd1] <= stack_value;
      end
    end
  end

  // Handshake one key; returns just after the accepting edge.
  task automatic send_key(input logic [4:0] k);
    int guard = 0;
    @(negedge clock);
    while (!key_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!key_ready) begin
      total++;
      bad++;
      $display("FAIL send_key_timeout: key_ready=%b required 1", key_ready);
    end
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clock);
    #1 key_valid = 1'b0;
  endtask

  // Send a key and capture the EXEC-cycle controls {push,pop,write,clear}.
  task automatic press(input logic [4:0] k, output logic [3:0] ctl, output logic [31:0] val);
    send_key(k);
    @(negedge clock);
    ctl = {stack_push, stack_pop, stack_write, stack_clear};
    val = stack_value;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    model_rst = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", key_ready); end
    total++;
    if ({busy, stack_push, stack_pop, stack_write, stack_clear} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 00000", {busy, stack_push, stack_pop, stack_write, stack_clear});
    end
    total++;
    if (stack_value !== 32'd0) begin bad++; $display("FAIL reset_value: got %h want 0", stack_value); end
    total++;
    if ({err_underflow, err_divzero, err_full} !== 3'b0) begin
      bad++; $display("FAIL reset_err: got %b want 000", {err_underflow, err_divzero, err_full});
    end
  endtask

  task automatic test_entry_add();
    logic [4:0]  k [5];
    logic [3:0]  c [5];
    logic [31:0] v [5];
    logic [3:0]  ctl;
    logic [31:0] val;
    k = '{5'd1, 5'd2, 5'd10, 5'd3, 5'd11};
    c = '{4'h2, 4'h2, 4'h8,  4'h2, 4'h6};
    v = '{32'd1, 32'd12, 32'd0, 32'd3, 32'd15};
    for (int i = 0; i < 5; i++) begin
      press(k[i], ctl, val);
      total++;
      if (ctl !== c[i]) begin bad++; $display("FAIL entry_ctl[%0d]: got %h want %h", i, ctl, c[i]); end
      if (c[i][1]) begin
        total++;
        if (val !== v[i]) begin bad++; $display("FAIL entry_val[%0d]: got %0d want %0d", i, val, v[i]); end
      end
    end
    repeat (2) @(negedge clock);
    total++;
    if (stack_top !== 32'd15 || stack_count !== 6'd1) begin
      bad++; $display("FAIL entry_final: top=%0d count=%0d want 15/1", stack_top, stack_count);
    end
  endtask

  task automatic test_arith();
    logic [4:0]  k [12];
    logic [3:0]  c [12];
    logic [31:0] v [12];
    logic [3:0]  ctl;
    logic [31:0] val;
    k = '{5'd17, 5'd9, 5'd10, 5'd4, 5'd12, 5'd10, 5'd6, 5'd13, 5'd15, 5'd16, 5'd10, 5'd16};
    c = '{4'h1,  4'h2, 4'h8,  4'h2, 4'h6,  4'h8,  4'h2, 4'h6,  4'h2,  4'h2,  4'h8,  4'h4};
    v = '{32'd0, 32'd9, 32'd0, 32'd4, 32'd5, 32'd0, 32'd6, 32'd30, 32'hFFFFFFE2, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 12; i++) begin
      press(k[i], ctl, val);
      total++;
      if (ctl !== c[i]) begin bad++; $display("FAIL arith_ctl[%0d]: got %h want %h", i, ctl, c[i]); end
      if (c[i][1]) begin
        total++;
        if (val !== v[i]) begin bad++; $display("FAIL arith_val[%0d]: got %h want %h", i, val, v[i]); end
      end
    end
    repeat (2) @(negedge clock);
    total++;
    if (stack_top !== 32'd0 || stack_count !== 6'd1) begin
      bad++; $display("FAIL arith_final: top=%0d count=%0d want 0/1", stack_top, stack_count);
    end
  endtask

  task automatic test_divzero_clear();
    logic [4:0] k [5];
    logic [3:0] c [5];
    logic [3:0]  ctl;
    logic [31:0] val;
    k = '{5'd17, 5'd7, 5'd10, 5'd0, 5'd14};
    c = '{4'h1,  4'h2, 4'h8,  4'h2, 4'h0};
    for (int i = 0; i < 5; i++) begin
      press(k[i], ctl, val);
      total++;
      if (ctl !== c[i]) begin bad++; $display("FAIL divzero_ctl[%0d]: got %h want %h", i, ctl, c[i]); end
    end
    @(negedge clock);
    total++;
    if ({err_underflow, err_divzero, err_full} !== 3'b010) begin
      bad++; $display("FAIL divzero_flags: got %b want 010", {err_underflow, err_divzero, err_full});
    end
    total++;
    if (stack_top !== 32'd0 || stack_count !== 6'd2) begin
      bad++; $display("FAIL divzero_stack: top=%0d count=%0d want 0/2", stack_top, stack_count);
    end
    press(5'd17, ctl, val);
    @(negedge clock);
    total++;
    if ({err_underflow, err_divzero, err_full} !== 3'b000 || stack_count !== 6'd1) begin
      bad++; $display("FAIL clear_flags: flags=%b count=%0d want 000/1", {err_underflow, err_divzero, err_full}, stack_count);
    end
  endtask

  task automatic test_div();
    logic [4:0]  k [5];
    logic [3:0]  c [5];
    logic [31:0] v [5];
    logic [3:0]  ctl;
    logic [31:0] val;
    int nb = 0;
    int rdy_hi = 0;
    int g = 0;
    k = '{5'd17, 5'd7, 5'd15, 5'd10, 5'd2};
    c = '{4'h1,  4'h2, 4'h2,  4'h8,  4'h2};
    v = '{32'd0, 32'd7, 32'hFFFFFFF9, 32'd0, 32'd2};
    for (int i = 0; i < 5; i++) begin
      press(k[i], ctl, val);
      total++;
      if (ctl !== c[i] || (c[i][1] && val !== v[i])) begin
        bad++; $display("FAIL div_setup[%0d]: ctl=%h val=%h want %h/%h", i, ctl, val, c[i], v[i]);
      end
    end
    send_key(5'd14);
    @(negedge clock);
    while (busy === 1'b1 && g < 200) begin
      nb++;
      if (key_ready !== 1'b0) rdy_hi++;
      g++;
      @(negedge clock);
    end
    total++;
    if (nb != 33) begin bad++; $display("FAIL div_busy_cycles: got %0d want 33", nb); end
    total++;
    if (rdy_hi != 0) begin bad++; $display("FAIL div_ready_while_busy: got %0d cycles want 0", rdy_hi); end
    total++;
    if ({stack_push, stack_pop, stack_write, stack_clear} !== 4'h6 || stack_value !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_result: ctl=%h val=%h want 6/fffffffd",
                      {stack_push, stack_pop, stack_write, stack_clear}, stack_value);
    end
    @(negedge clock);
    total++;
    if (key_ready !== 1'b0) begin bad++; $display("FAIL div_settle_ready: got %b want 0", key_ready); end
    @(negedge clock);
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL div_ready_return: got %b want 1", key_ready); end
    total++;
    if (stack_top !== 32'hFFFFFFFD || stack_count !== 6'd1) begin
      bad++; $display("FAIL div_stack: top=%h count=%0d want fffffffd/1", stack_top, stack_count);
    end
  endtask

  // 2147483648 wraps to 0x80000000; dividing by -1 must give 0x80000000.
  task automatic test_div_min();
    logic [4:0]  k [14];
    logic [3:0]  ctl;
    logic [31:0] val;
    int g = 0;
    k = '{5'd17, 5'd2, 5'd1, 5'd4, 5'd7, 5'd4, 5'd8, 5'd3, 5'd6, 5'd4, 5'd8, 5'd10, 5'd1, 5'd15};
    for (int i = 0; i < 14; i++) press(k[i], ctl, val);
    @(negedge clock);
    total++;
    if (stack_next !== 32'h80000000 || stack_top !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL divmin_operands: next=%h top=%h want 80000000/ffffffff", stack_next, stack_top);
    end
    send_key(5'd14);
    @(negedge clock);
    while (busy === 1'b1 && g < 200) begin
      g++;
      @(negedge clock);
    end
    total++;
    if ({stack_pop, stack_write} !== 2'b11 || stack_value !== 32'h80000000) begin
      bad++; $display("FAIL divmin_result: popwr=%b val=%h want 11/80000000", {stack_pop, stack_write}, stack_value);
    end
  endtask

  task automatic test_underflow();
    logic [3:0]  ctl;
    logic [31:0] val;
    press(5'd17, ctl, val);
    press(5'd11, ctl, val);
    total++;
    if (ctl !== 4'h0 || key_ready !== 1'b0) begin
      bad++; $display("FAIL underflow_exec: ctl=%h ready=%b want 0/0", ctl, key_ready);
    end
    @(negedge clock);
    total++;
    if (err_underflow !== 1'b1 || key_ready !== 1'b0) begin
      bad++; $display("FAIL underflow_flag: err=%b ready=%b want 1/0", err_underflow, key_ready);
    end
    @(negedge clock);
    total++;
    if (key_ready !== 1'b1 || stack_count !== 6'd1) begin
      bad++; $display("FAIL underflow_ready: ready=%b count=%0d want 1/1", key_ready, stack_count);
    end
  endtask

  task automatic test_full();
    logic [3:0]  ctl;
    logic [31:0] val;
    int npush = 0;
    press(5'd17, ctl, val);
    for (int i = 0; i < 63; i++) begin
      press(5'd10, ctl, val);
      if (ctl == 4'h8) npush++;
    end
    repeat (2) @(negedge clock);
    total++;
    if (npush != 63 || stack_count !== 6'd0) begin
      bad++; $display("FAIL full_fill: pushes=%0d count=%0d want 63/0", npush, stack_count);
    end
    press(5'd10, ctl, val);
    total++;
    if (ctl !== 4'h0) begin bad++; $display("FAIL full_nopush: got %h want 0", ctl); end
    @(negedge clock);
    total++;
    if (err_full !== 1'b1 || stack_count !== 6'd0) begin
      bad++; $display("FAIL full_flag: err=%b count=%0d want 1/0", err_full, stack_count);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [3:0]  ctl;
    logic [31:0] val;
    int w0;
    int p0;
    press(5'd17, ctl, val);
    press(5'd5, ctl, val);
    press(5'd10, ctl, val);
    press(5'd1, ctl, val);
    send_key(5'd14);
    repeat (10) @(negedge clock);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL middiv_busy: got %b want 1", busy); end
    w0 = n_write;
    p0 = n_pop;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL middiv_release: ready=%b busy=%b want 1/0", key_ready, busy);
    end
    repeat (40) @(negedge clock);
    total++;
    if (n_write != w0 || n_pop != p0) begin
      bad++; $display("FAIL middiv_nowrite: writes=%0d pops=%0d want %0d/%0d", n_write, n_pop, w0, p0);
    end
    total++;
    if (stack_top !== 32'd1 || stack_count !== 6'd2) begin
      bad++; $display("FAIL middiv_stack: top=%0d count=%0d want 1/2", stack_top, stack_count);
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (n_both != 0) begin bad++; $display("FAIL push_pop_together: got %0d cycles want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_entry_add();
    test_arith();
    test_divzero_clear();
    test_div();
    test_div_min();
    test_underflow();
    test_full();
    test_reset_mid_div();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
